// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage encodings: ALU control codes, ALU_OP_* and FUNCT_* constants.
// Also defines the registered ID/EX control bundle and its bubble value.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_ctrl;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    alu_ctrl:   ALU_ADD
  };

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control decode: (alu_op, funct) -> 4-bit ALU code.
// Unlisted R-type functs fall back to add.
module alu_control (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);
  import mips_pkg::*;

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_OR:  alu_ctrl = ALU_OR;
      default: begin
        unique case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, stall/flush and ALU operand select.
// Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_alu_out,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_data,
  output logic                  load_use_stall,
  output logic [DATA_W-1:0]     alu_n1,
  output logic [DATA_W-1:0]     alu_n2,
  output logic [3:0]            alu_ctrl,
  output logic [REG_ADDR_W-1:0] ex_write_reg,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg
);
  import mips_pkg::*;

  logic [3:0] id_alu_ctrl;

  alu_control u_alu_control (
    .alu_op   (id_alu_op),
    .funct    (id_funct),
    .alu_ctrl (id_alu_ctrl)
  );

  id_ex_ctrl_t           ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     fwd_rs, fwd_rt;

  assign load_use_stall = ctrl_q.mem_read
                       && (rt_q != '0)
                       && ((rt_q == id_rs) || (rt_q == id_rt));

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    wreg_d    = wreg_q;
    if (flush || (!stall && load_use_stall)) begin
      ctrl_d    = ID_EX_BUBBLE;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      wreg_d    = '0;
    end else if (!stall) begin
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.alu_src    = id_alu_src;
      ctrl_d.alu_ctrl   = id_alu_ctrl;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      wreg_d    = id_reg_dst ? id_rd : id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= ID_EX_BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wreg_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      wreg_q    <= wreg_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger result, so it overrides MEM/WB.
  always_comb begin
    fwd_rs = rs_data_q;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_alu_out;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_alu_out;
  end
`else
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;

  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_alu_out,
                        memwb_reg_write, memwb_rd, memwb_data, rs_q};
`endif

  assign alu_n1        = fwd_rs;
  assign alu_n2        = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = ctrl_q.alu_ctrl;
  assign ex_write_reg  = wreg_q;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random stimulus
// compared every cycle against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst;
  logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_alu_out, memwb_data;
  logic        load_use_stall;
  logic [31:0] alu_n1, alu_n2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_write_reg;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data),
    .load_use_stall(load_use_stall),
    .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_ctrl(alu_ctrl),
    .ex_write_reg(ex_write_reg), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // Instruction currently held in EX, as the model sees it.
  typedef struct {
    bit        mr, mw, rw, m2r, src;
    int        code;
    int        rs, rt, wreg;
    bit [31:0] a, b, imm;
  } instr_t;

  instr_t m;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic int ref_code(int op, int f);
    if (op == 0) return 2;
    if (op == 1) return 6;
    if (op == 3) return 1;
    if (f == 32) return 2;
    if (f == 34) return 6;
    if (f == 36) return 0;
    if (f == 37) return 1;
    if (f == 42) return 7;
    return 2;
  endfunction

  function automatic bit [31:0] ref_fwd(int r, bit [31:0] v);
    if (FWD && r != 0) begin
      if (exmem_reg_write && int'(exmem_rd) == r) return exmem_alu_out;
      if (memwb_reg_write && int'(memwb_rd) == r) return memwb_data;
    end
    return v;
  endfunction

  function automatic bit ref_hazard();
    return m.mr && m.rt != 0 && (m.rt == int'(id_rs) || m.rt == int'(id_rt));
  endfunction

  function automatic instr_t bubble();
    instr_t b;
    b.mr = 0; b.mw = 0; b.rw = 0; b.m2r = 0; b.src = 0;
    b.code = 2; b.rs = 0; b.rt = 0; b.wreg = 0;
    b.a = 0; b.b = 0; b.imm = 0;
    return b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit [31:0] fa, fb;
    fa = ref_fwd(m.rs, m.a);
    fb = ref_fwd(m.rt, m.b);
    check("load_use_stall", 32'(load_use_stall), 32'(ref_hazard()));
    check("alu_n1", alu_n1, fa);
    check("alu_n2", alu_n2, m.src ? m.imm : fb);
    check("store_data", ex_store_data, fb);
    check("alu_ctrl", 32'(alu_ctrl), 32'(m.code));
    check("write_reg", 32'(ex_write_reg), 32'(m.wreg));
    check("ctrl_bits", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
          {28'd0, m.mr, m.mw, m.rw, m.m2r});
  endtask

  task automatic model_update();
    bit hz;
    hz = ref_hazard();
    if (rst || flush) m = bubble();
    else if (stall) m = m;
    else if (hz) m = bubble();
    else begin
      m.mr = id_mem_read; m.mw = id_mem_write;
      m.rw = id_reg_write; m.m2r = id_mem_to_reg;
      m.src = id_alu_src;
      m.code = ref_code(int'(id_alu_op), int'(id_funct));
      m.rs = int'(id_rs); m.rt = int'(id_rt);
      m.wreg = id_reg_dst ? int'(id_rd) : int'(id_rt);
      m.a = id_rs_data; m.b = id_rt_data; m.imm = id_imm;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_funct = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_dst = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_alu_out = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic randomize_inputs();
    int fsel;
    rst   = ($urandom_range(0, 99) == 0);
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 9) == 0);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 31));
    id_alu_op = 2'($urandom_range(0, 3));
    fsel = $urandom_range(0, 5);
    case (fsel)
      0: id_funct = 6'b100000;
      1: id_funct = 6'b100010;
      2: id_funct = 6'b100100;
      3: id_funct = 6'b100101;
      4: id_funct = 6'b101010;
      default: id_funct = 6'($urandom);
    endcase
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
    exmem_reg_write = 1'($urandom);
    exmem_rd = 5'($urandom_range(0, 3));
    exmem_alu_out = $urandom;
    memwb_reg_write = 1'($urandom);
    memwb_rd = 5'($urandom_range(0, 3));
    memwb_data = $urandom;
  endtask

  initial begin
    m = bubble();
    clear_inputs();
    rst = 1;
    advance();
    advance();
    sample();
    check("rst_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'h2);
    check("rst_n1", alu_n1, 32'd0);
    check("rst_n2", alu_n2, 32'd0);
    rst = 0;

    // slt rs=5 rt=6
    id_alu_op = 2'b10; id_funct = 6'b101010;
    id_rs = 5; id_rt = 6; id_rd = 7; id_reg_dst = 1; id_reg_write = 1;
    id_rs_data = 3; id_rt_data = 7;
    advance();
    sample();
    check("slt_ctrl", 32'(alu_ctrl), 32'h7);
    check("slt_n1", alu_n1, 32'd3);
    check("slt_n2", alu_n2, 32'd7);

    exmem_reg_write = 1; exmem_rd = 5; exmem_alu_out = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_data = 32'hBB;
    #1;
    check("fwd_exmem", alu_n1, FWD ? 32'hAA : 32'd3);
    exmem_reg_write = 0;
    #1;
    check("fwd_memwb", alu_n1, FWD ? 32'hBB : 32'd3);
    clear_inputs();
    id_rs = 0; id_rs_data = 32'h55; id_alu_op = 2'b00;
    advance();

    exmem_reg_write = 1; exmem_rd = 0; exmem_alu_out = 32'hAA;
    sample();
    check("no_fwd_r0", alu_n1, 32'h55);

    clear_inputs();
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    id_rs = 1; id_rt = 8; id_alu_src = 1; id_imm = 4;
    advance();
    clear_inputs();
    id_rs = 8; id_rt = 2; id_rd = 9; id_reg_dst = 1; id_reg_write = 1;
    id_alu_op = 2'b10; id_funct = 6'b100000;
    sample();
    check("lu_stall", 32'(load_use_stall), 32'd1);
    advance();
    sample();
    check("lu_bubble", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);
    check("lu_released", 32'(load_use_stall), 32'd0);
    advance();
    sample();
    check("lu_reload_rw", 32'(ex_reg_write), 32'd1);
    check("lu_reload_wreg", 32'(ex_write_reg), 32'd9);

    stall = 1; flush = 1;
    advance();
    sample();
    check("flush_wins", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);
    check("flush_code", 32'(alu_ctrl), 32'h2);
    clear_inputs();
    id_alu_op = 2'b01; id_rt = 3; id_rd = 7; id_mem_write = 1;
    id_rs_data = 32'h11; id_rt_data = 32'h22; id_alu_src = 1; id_imm = 32'h44;
    advance();
    clear_inputs();
    stall = 1; id_alu_op = 2'b11; id_rt = 1; id_reg_write = 1; id_imm = 32'h99;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("hold_code", 32'(alu_ctrl), 32'h6);
      check("hold_wreg", 32'(ex_write_reg), 32'd3);
      check("hold_n2", alu_n2, 32'h44);
      check("hold_store", ex_store_data, 32'h22);
      check("hold_mw", 32'(ex_mem_write), 32'd1);
      advance();
    end

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
